// File: rtl/vx_tensor_commit_seq.sv
// vx_tensor_commit_seq
//
// Commit sequencer for the tensor unit. Tensor instructions from dispatch
// have their commit metadata queued in one FIFO per warp. A round-robin
// arbiter picks a non-empty warp. That instruction is then drained as a burst
// of NUM_UOPS writeback beats. Beat k < NUM_UOPS-1 writes accumulator
// register ACC_BASE+k with wb forced on. The last beat carries the
// instruction's own rd/wb and pops the FIFO entry.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   exe_*                 dispatch handshake and instruction metadata
//   acc_wid / acc_idx     warp and beat index of the current beat; they drive
//                         an external combinational lookup
//   acc_data              data returned by that lookup, passed to commit_data
//   commit_*              one writeback beat per commit_valid/commit_ready fire
//   busy                  a FIFO holds an entry or a burst is in progress
module vx_tensor_commit_seq #(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int XLEN        = 32,
  parameter int UUID_WIDTH  = 44,
  parameter int NR_BITS     = 6,
  parameter int QUEUE_DEPTH = 16,
  parameter int NUM_UOPS    = 4,
  parameter int ACC_BASE    = 32,
  localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int IDX_W = (NUM_UOPS > 1) ? $clog2(NUM_UOPS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,

  input  logic                        exe_valid,
  output logic                        exe_ready,
  input  logic [UUID_WIDTH-1:0]       exe_uuid,
  input  logic [WID_W-1:0]            exe_wid,
  input  logic [NUM_THREADS-1:0]      exe_tmask,
  input  logic [XLEN-1:0]             exe_PC,
  input  logic                        exe_wb,
  input  logic [NR_BITS-1:0]          exe_rd,

  output logic [WID_W-1:0]            acc_wid,
  output logic [IDX_W-1:0]            acc_idx,
  input  logic [NUM_THREADS*XLEN-1:0] acc_data,

  output logic                        commit_valid,
  input  logic                        commit_ready,
  output logic [UUID_WIDTH-1:0]       commit_uuid,
  output logic [WID_W-1:0]            commit_wid,
  output logic [NUM_THREADS-1:0]      commit_tmask,
  output logic [XLEN-1:0]             commit_PC,
  output logic                        commit_wb,
  output logic [NR_BITS-1:0]          commit_rd,
  output logic [NUM_THREADS*XLEN-1:0] commit_data,
  output logic                        commit_pid,
  output logic                        commit_sop,
  output logic                        commit_eop,

  output logic                        busy
);

  localparam int ADDR_W = $clog2(QUEUE_DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  if (ACC_BASE + NUM_UOPS - 2 >= (1 << NR_BITS)) begin : g_acc_range_check
    $error("vx_tensor_commit_seq: ACC_BASE+NUM_UOPS-2 exceeds the register index range");
  end

  typedef struct packed {
    logic [UUID_WIDTH-1:0]  uuid;
    logic [WID_W-1:0]       wid;
    logic [NUM_THREADS-1:0] tmask;
    logic [XLEN-1:0]        pc;
    logic                   wb;
    logic [NR_BITS-1:0]     rd;
  } entry_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  entry_t           mem_q    [NUM_WARPS][QUEUE_DEPTH];
  entry_t           mem_d    [NUM_WARPS][QUEUE_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q [NUM_WARPS];
  logic [PTR_W-1:0] rd_ptr_d [NUM_WARPS];
  logic [PTR_W-1:0] wr_ptr_q [NUM_WARPS];
  logic [PTR_W-1:0] wr_ptr_d [NUM_WARPS];

  state_t           state_q, state_d;
  logic [WID_W-1:0] g_q, g_d;
  logic [WID_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] k_q, k_d;

  logic [NUM_WARPS-1:0] empty;
  logic [NUM_WARPS-1:0] full;
  logic                 push;
  logic                 last_beat;
  entry_t               head;
  entry_t               new_entry;

  logic                 grant_found;
  logic [WID_W-1:0]     grant_wid;
  logic [WID_W-1:0]     grant_next;

  // The pointers carry one extra wrap bit, so full and empty are told apart
  // without a separate occupancy counter.
  always_comb begin
    empty = '0;
    full  = '0;
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      empty[WID_W'(w)] = (rd_ptr_q[WID_W'(w)] == wr_ptr_q[WID_W'(w)]);
      full[WID_W'(w)]  = ((wr_ptr_q[WID_W'(w)] - rd_ptr_q[WID_W'(w)]) == PTR_W'(QUEUE_DEPTH));
    end
  end

  // Ready depends only on the selected warp's registered FIFO status. A pop in
  // the same cycle does not free a slot early.
  always_comb begin
    exe_ready = 1'b0;
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      if (exe_wid == WID_W'(w)) exe_ready = !full[WID_W'(w)];
    end
  end

  assign push      = exe_valid && exe_ready;
  assign last_beat = (k_q == IDX_W'(NUM_UOPS - 1));
  assign head      = mem_q[g_q][rd_ptr_q[g_q][ADDR_W-1:0]];

  always_comb begin
    new_entry       = '0;
    new_entry.uuid  = exe_uuid;
    new_entry.wid   = exe_wid;
    new_entry.tmask = exe_tmask;
    new_entry.pc    = exe_PC;
    new_entry.wb    = exe_wb;
    new_entry.rd    = exe_rd;
  end

  // The round-robin search starts at rr_q, the warp after the last grant.
  always_comb begin
    grant_found = 1'b0;
    grant_wid   = '0;
    grant_next  = '0;
    for (int unsigned i = 0; i < NUM_WARPS; i++) begin
      if (!grant_found && !empty[WID_W'((32'(rr_q) + i) % NUM_WARPS)]) begin
        grant_found = 1'b1;
        grant_wid   = WID_W'((32'(rr_q) + i) % NUM_WARPS);
        grant_next  = WID_W'((32'(rr_q) + i + 1) % NUM_WARPS);
      end
    end
  end

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    state_d  = state_q;
    g_d      = g_q;
    rr_d     = rr_q;
    k_d      = k_q;

    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      if (push && exe_wid == WID_W'(w)) begin
        mem_d[WID_W'(w)][wr_ptr_q[WID_W'(w)][ADDR_W-1:0]] = new_entry;
        wr_ptr_d[WID_W'(w)] = wr_ptr_q[WID_W'(w)] + PTR_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          state_d = S_BURST;
          g_d     = grant_wid;
          rr_d    = grant_next;
          k_d     = '0;
        end
      end
      S_BURST: begin
        if (commit_ready) begin
          if (last_beat) begin
            rd_ptr_d[g_q] = rd_ptr_q[g_q] + PTR_W'(1);
            state_d       = S_IDLE;
          end else begin
            k_d = k_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      g_q      <= '0;
      rr_q     <= '0;
      k_q      <= '0;
      rd_ptr_q <= '{default: '0};
      wr_ptr_q <= '{default: '0};
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      rr_q     <= rr_d;
      k_q      <= k_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // The storage array needs no reset. The pointers alone define what it holds.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Beat outputs are decoded from registered state and FIFO contents only.
  // They are forced to zero outside a burst.
  always_comb begin
    commit_valid = (state_q == S_BURST);
    commit_uuid  = '0;
    commit_wid   = '0;
    commit_tmask = '0;
    commit_PC    = '0;
    commit_wb    = 1'b0;
    commit_rd    = '0;
    commit_sop   = 1'b0;
    commit_eop   = 1'b0;
    if (state_q == S_BURST) begin
      commit_uuid  = head.uuid;
      commit_wid   = head.wid;
      commit_tmask = head.tmask;
      commit_PC    = head.pc;
      commit_sop   = (k_q == '0);
      commit_eop   = last_beat;
      commit_wb    = last_beat ? head.wb : 1'b1;
      commit_rd    = last_beat ? head.rd : (NR_BITS'(ACC_BASE) + NR_BITS'(k_q));
    end
  end

  assign commit_pid  = 1'b0;
  assign commit_data = acc_data;
  assign acc_wid     = g_q;
  assign acc_idx     = k_q;
  assign busy        = (state_q == S_BURST) || (|(~empty));

endmodule

// File: tb/tb_vx_tensor_commit_seq.sv
// Directed bench for vx_tensor_commit_seq. It uses a four-beat instance and
// a single-beat instance that share the clock, the reset and the instruction
// fields.
module tb_vx_tensor_commit_seq;

  logic         clk = 1'b0;
  logic         reset = 1'b1;

  logic         exe_valid = 1'b0, exe_valid1 = 1'b0;
  logic         exe_ready, exe_ready1;
  logic [43:0]  exe_uuid = '0;
  logic [1:0]   exe_wid = '0;
  logic [3:0]   exe_tmask = '0;
  logic [31:0]  exe_PC = '0;
  logic         exe_wb = 1'b0;
  logic [5:0]   exe_rd = '0;

  logic [1:0]   acc_wid, acc_wid1;
  logic [1:0]   acc_idx;
  logic [0:0]   acc_idx1;
  logic [127:0] acc_data, acc_data1;

  logic         commit_valid, commit_valid1;
  logic         commit_ready = 1'b1, commit_ready1 = 1'b1;
  logic [43:0]  commit_uuid, commit_uuid1;
  logic [1:0]   commit_wid, commit_wid1;
  logic [3:0]   commit_tmask, commit_tmask1;
  logic [31:0]  commit_PC, commit_PC1;
  logic         commit_wb, commit_wb1;
  logic [5:0]   commit_rd, commit_rd1;
  logic [127:0] commit_data, commit_data1;
  logic         commit_pid, commit_pid1;
  logic         commit_sop, commit_sop1;
  logic         commit_eop, commit_eop1;
  logic         busy, busy1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [127:0] mk_data(input logic [1:0] w, input logic [1:0] k);
    return {4{8'hA5, 14'h0, w, 6'h0, k}};
  endfunction

  assign acc_data  = mk_data(acc_wid, acc_idx);
  assign acc_data1 = mk_data(acc_wid1, {1'b0, acc_idx1});

  vx_tensor_commit_seq #(.NUM_WARPS(4), .NUM_THREADS(4), .XLEN(32), .UUID_WIDTH(44),
    .NR_BITS(6), .QUEUE_DEPTH(16), .NUM_UOPS(4), .ACC_BASE(32)) dut (
    .clk(clk), .reset(reset),
    .exe_valid(exe_valid), .exe_ready(exe_ready), .exe_uuid(exe_uuid), .exe_wid(exe_wid),
    .exe_tmask(exe_tmask), .exe_PC(exe_PC), .exe_wb(exe_wb), .exe_rd(exe_rd),
    .acc_wid(acc_wid), .acc_idx(acc_idx), .acc_data(acc_data),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_uuid(commit_uuid),
    .commit_wid(commit_wid), .commit_tmask(commit_tmask), .commit_PC(commit_PC),
    .commit_wb(commit_wb), .commit_rd(commit_rd), .commit_data(commit_data),
    .commit_pid(commit_pid), .commit_sop(commit_sop), .commit_eop(commit_eop), .busy(busy));

  vx_tensor_commit_seq #(.NUM_WARPS(4), .NUM_THREADS(4), .XLEN(32), .UUID_WIDTH(44),
    .NR_BITS(6), .QUEUE_DEPTH(16), .NUM_UOPS(1), .ACC_BASE(32)) dut1 (
    .clk(clk), .reset(reset),
    .exe_valid(exe_valid1), .exe_ready(exe_ready1), .exe_uuid(exe_uuid), .exe_wid(exe_wid),
    .exe_tmask(exe_tmask), .exe_PC(exe_PC), .exe_wb(exe_wb), .exe_rd(exe_rd),
    .acc_wid(acc_wid1), .acc_idx(acc_idx1), .acc_data(acc_data1),
    .commit_valid(commit_valid1), .commit_ready(commit_ready1), .commit_uuid(commit_uuid1),
    .commit_wid(commit_wid1), .commit_tmask(commit_tmask1), .commit_PC(commit_PC1),
    .commit_wb(commit_wb1), .commit_rd(commit_rd1), .commit_data(commit_data1),
    .commit_pid(commit_pid1), .commit_sop(commit_sop1), .commit_eop(commit_eop1), .busy(busy1));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] ex);
    total++;
    assert (obs === ex) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, ex);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [31:0] pc_of(input logic [43:0] u);
    return 32'h0000_1000 | {16'h0, u[15:0]};
  endfunction

  // Drives one instruction for a single cycle. It is called at a negedge.
  task automatic enq(input logic [1:0] w, input logic [43:0] u, input logic [5:0] rd,
                     input logic wb, input bit to_single);
    exe_wid   = w;
    exe_uuid  = u;
    exe_tmask = u[3:0];
    exe_PC    = pc_of(u);
    exe_wb    = wb;
    exe_rd    = rd;
    if (to_single) exe_valid1 = 1'b1; else exe_valid = 1'b1;
    #1;
    chk("enq_ready", 128'(to_single ? exe_ready1 : exe_ready), 128'(1));
    tick();
    exe_valid  = 1'b0;
    exe_valid1 = 1'b0;
  endtask

  // Follows one four-beat burst to its end. Each cycle it checks the beat
  // fields against the expected beat number. In back-pressure mode
  // commit_ready follows the pattern 1,0,0,1,0,0...
  task automatic drain(input logic [1:0] w, input logic [43:0] u, input logic [5:0] rd,
                       input logic wb, input bit bp);
    int  nf    = 0;
    int  c     = 0;
    int  guard = 0;
    bit  last;
    while (!commit_valid && guard < 100) begin
      tick();
      guard++;
    end
    chk("burst_start", 128'(commit_valid), 128'(1));
    while (nf < 4 && guard < 200) begin
      commit_ready = bp ? (c % 3 == 0) : 1'b1;
      last = (nf == 3);
      chk("beat_valid", 128'(commit_valid), 128'(1));
      chk("beat_rd",    128'(commit_rd),    128'(last ? rd : 6'(32 + nf)));
      chk("beat_wb",    128'(commit_wb),    128'(last ? wb : 1'b1));
      chk("beat_sop",   128'(commit_sop),   128'(nf == 0));
      chk("beat_eop",   128'(commit_eop),   128'(last));
      chk("beat_pid",   128'(commit_pid),   128'(0));
      chk("beat_uuid",  128'(commit_uuid),  128'(u));
      chk("beat_wid",   128'(commit_wid),   128'(w));
      chk("beat_tmask", 128'(commit_tmask), 128'(u[3:0]));
      chk("beat_pc",    128'(commit_PC),    128'(pc_of(u)));
      chk("acc_wid",    128'(acc_wid),      128'(w));
      chk("acc_idx",    128'(acc_idx),      128'(nf));
      chk("beat_data",  commit_data,        mk_data(w, 2'(nf)));
      if (commit_valid && commit_ready) nf++;
      c++;
      guard++;
      tick();
    end
    chk("fire_count", 128'(nf), 128'(4));
  endtask

  task automatic chk_single(input logic [43:0] u, input logic [5:0] rd, input logic wb);
    chk("s_valid", 128'(commit_valid1), 128'(1));
    chk("s_uuid",  128'(commit_uuid1),  128'(u));
    chk("s_rd",    128'(commit_rd1),    128'(rd));
    chk("s_wb",    128'(commit_wb1),    128'(wb));
    chk("s_sop",   128'(commit_sop1),   128'(1));
    chk("s_eop",   128'(commit_eop1),   128'(1));
    chk("s_pid",   128'(commit_pid1),   128'(0));
    chk("s_wid",   128'(commit_wid1),   128'(0));
    chk("s_tmask", 128'(commit_tmask1), 128'(u[3:0]));
    chk("s_pc",    128'(commit_PC1),    128'(pc_of(u)));
    chk("s_idx",   128'(acc_idx1),      128'(0));
    chk("s_data",  commit_data1,        mk_data(2'd0, 2'd0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    tick();
    tick();
    chk("rst_exe_ready", 128'(exe_ready),    128'(1));
    chk("rst_valid",     128'(commit_valid), 128'(0));
    chk("rst_sop",       128'(commit_sop),   128'(0));
    chk("rst_eop",       128'(commit_eop),   128'(0));
    chk("rst_pid",       128'(commit_pid),   128'(0));
    chk("rst_busy",      128'(busy),         128'(0));
    chk("rst_acc_wid",   128'(acc_wid),      128'(0));
    chk("rst_acc_idx",   128'(acc_idx),      128'(0));
    chk("rst_rd",        128'(commit_rd),    128'(0));
    chk("rst_uuid",      128'(commit_uuid),  128'(0));
    chk("rst_wb",        128'(commit_wb),    128'(0));
    reset = 1'b0;

    // Single instruction: grant cycle, then the first beat two cycles after enqueue
    enq(2'd0, 44'h11, 6'd5, 1'b1, 1'b0);
    chk("t1_grant_idle", 128'(commit_valid), 128'(0));
    chk("t1_busy",       128'(busy),         128'(1));
    tick();
    chk("t1_first_beat", 128'(commit_valid), 128'(1));
    drain(2'd0, 44'h11, 6'd5, 1'b1, 1'b0);
    chk("t1_idle_after", 128'(commit_valid), 128'(0));
    chk("t1_busy_after", 128'(busy),         128'(0));

    // Back-pressure
    enq(2'd0, 44'h12, 6'd5, 1'b1, 1'b0);
    drain(2'd0, 44'h12, 6'd5, 1'b1, 1'b1);
    commit_ready = 1'b1;
    chk("bp_idle_after", 128'(commit_valid), 128'(0));
    chk("bp_busy_after", 128'(busy),         128'(0));

    // Round-robin. A warp-3 burst is held stalled while warps 2, 0, 3 queue.
    // Its grant leaves the pointer at warp 0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    commit_ready = 1'b0;
    enq(2'd3, 44'h30, 6'd8, 1'b1, 1'b0);
    enq(2'd2, 44'h20, 6'd8, 1'b1, 1'b0);
    enq(2'd0, 44'h01, 6'd8, 1'b1, 1'b0);
    enq(2'd3, 44'h31, 6'd8, 1'b1, 1'b0);
    commit_ready = 1'b1;
    drain(2'd3, 44'h30, 6'd8, 1'b1, 1'b0);
    drain(2'd0, 44'h01, 6'd8, 1'b1, 1'b0);
    drain(2'd2, 44'h20, 6'd8, 1'b1, 1'b0);
    commit_ready = 1'b0;
    enq(2'd1, 44'h41, 6'd8, 1'b1, 1'b0);
    chk("rr_w3_granted", 128'(commit_wid),  128'(3));
    chk("rr_w3_uuid",    128'(commit_uuid), 128'(44'h31));
    enq(2'd0, 44'h42, 6'd8, 1'b1, 1'b0);
    commit_ready = 1'b1;
    drain(2'd3, 44'h31, 6'd8, 1'b1, 1'b0);
    drain(2'd0, 44'h42, 6'd8, 1'b1, 1'b0);
    drain(2'd1, 44'h41, 6'd8, 1'b1, 1'b0);

    // Full queue
    reset = 1'b1;
    tick();
    reset = 1'b0;
    commit_ready = 1'b0;
    for (int i = 0; i < 16; i++) enq(2'd1, 44'h100 + 44'(i), 6'd7, 1'b0, 1'b0);
    exe_valid = 1'b1;
    exe_wid   = 2'd1;
    exe_uuid  = 44'h1FF;
    #1;
    chk("full_w1_ready",  128'(exe_ready), 128'(0));
    exe_wid = 2'd2;
    #1;
    chk("full_w2_ready",  128'(exe_ready), 128'(1));
    exe_valid = 1'b0;
    chk("full_busy",      128'(busy),      128'(1));
    commit_ready = 1'b1;
    for (int i = 0; i < 16; i++) drain(2'd1, 44'h100 + 44'(i), 6'd7, 1'b0, 1'b0);
    chk("full_drained_busy", 128'(busy), 128'(0));

    // Reset during beat 1
    enq(2'd2, 44'h55, 6'd9, 1'b1, 1'b0);
    tick();
    chk("mid_beat0_idx", 128'(acc_idx), 128'(0));
    tick();
    chk("mid_beat1_valid", 128'(commit_valid), 128'(1));
    chk("mid_beat1_rd",    128'(commit_rd),    128'(33));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", 128'(commit_valid), 128'(0));
    chk("mid_rst_busy",  128'(busy),         128'(0));
    chk("mid_rst_eop",   128'(commit_eop),   128'(0));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mid_no_beat", 128'(commit_valid), 128'(0));
    end
    enq(2'd0, 44'h66, 6'd4, 1'b1, 1'b0);
    drain(2'd0, 44'h66, 6'd4, 1'b1, 1'b0);

    // Single-beat instance: one beat every two cycles
    enq(2'd0, 44'h71, 6'd9, 1'b1, 1'b1);
    chk("s_idle0", 128'(commit_valid1), 128'(0));
    enq(2'd0, 44'h72, 6'd10, 1'b0, 1'b1);
    chk_single(44'h71, 6'd9, 1'b1);
    enq(2'd0, 44'h73, 6'd11, 1'b1, 1'b1);
    chk("s_idle1", 128'(commit_valid1), 128'(0));
    tick();
    chk_single(44'h72, 6'd10, 1'b0);
    tick();
    chk("s_idle2", 128'(commit_valid1), 128'(0));
    tick();
    chk_single(44'h73, 6'd11, 1'b1);
    tick();
    chk("s_idle3", 128'(commit_valid1), 128'(0));
    chk("s_busy",  128'(busy1),         128'(0));
    chk("s_wid_acc", 128'(acc_wid1),    128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
